// File: rtl/uart_pkg.sv
// Shared UART types and helpers: rx FSM encoding and the mid-bit offset.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        STOP      = 3'd3,
        WAIT_IDLE = 3'd4
    } rx_state_t;

    function automatic int half_bit(input int clks);
        return (clks - 1) / 2;
    endfunction

endpackage

// File: rtl/uart_sync_2ff.sv
// Two-flop synchroniser for an asynchronous single-bit input.
module uart_sync_2ff #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic i_Clock,
    input  logic i_Rst_L,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge i_Clock or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: start-glitch rejection, mid-bit sampling, framing-error flag.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 217
) (
    input  logic       i_Clock,
    input  logic       i_Rst_L,
    input  logic       i_RX_Serial,
    output logic       o_RX_DV,
    output logic [7:0] o_RX_Byte,
    output logic       o_RX_Active,
    output logic       o_Frame_Err
);

    localparam int              CNT_W = $clog2(CLKS_PER_BIT) + 1;
    localparam logic [CNT_W-1:0] HALF = CNT_W'(half_bit(CLKS_PER_BIT));
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

    logic             r_sync;
    rx_state_t        state, state_n;
    logic [CNT_W-1:0] count, count_n;
    logic [2:0]       index, index_n;
    logic [7:0]       r_byte, r_byte_n, rx_byte_n;
    logic             dv_n, ferr_n, active_n;

    // Idle-high line: reset value 1 keeps reset release from looking like a start bit.
    uart_sync_2ff #(.RST_VAL(1'b1)) u_sync (
        .i_Clock (i_Clock),
        .i_Rst_L (i_Rst_L),
        .d       (i_RX_Serial),
        .q       (r_sync)
    );

    always_ff @(posedge i_Clock or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            state       <= IDLE;
            count       <= '0;
            index       <= '0;
            r_byte      <= '0;
            o_RX_Byte   <= '0;
            o_RX_DV     <= 1'b0;
            o_Frame_Err <= 1'b0;
            o_RX_Active <= 1'b0;
        end else begin
            state       <= state_n;
            count       <= count_n;
            index       <= index_n;
            r_byte      <= r_byte_n;
            o_RX_Byte   <= rx_byte_n;
            o_RX_DV     <= dv_n;
            o_Frame_Err <= ferr_n;
            o_RX_Active <= active_n;
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:      if (!r_sync) state_n = START;
            START:     if (count >= HALF) state_n = r_sync ? IDLE : DATA;
            DATA:      if (count >= LAST && index == 3'd7) state_n = STOP;
            STOP:      if (count >= LAST) state_n = r_sync ? IDLE : WAIT_IDLE;
            // A held-low break line must not be mistaken for a new start bit.
            WAIT_IDLE: if (r_sync) state_n = IDLE;
            default:   state_n = IDLE;
        endcase
    end

    always_comb begin
        count_n   = count;
        index_n   = index;
        r_byte_n  = r_byte;
        rx_byte_n = o_RX_Byte;
        dv_n      = 1'b0;
        ferr_n    = 1'b0;
        active_n  = o_RX_Active;
        case (state)
            START: begin
                if (count < HALF) begin
                    count_n = count + ONE;
                end else begin
                    count_n = '0;
                    if (!r_sync) active_n = 1'b1;
                end
            end
            DATA: begin
                if (count < LAST) begin
                    count_n = count + ONE;
                end else begin
                    count_n         = '0;
                    r_byte_n[index] = r_sync;
                    index_n         = (index == 3'd7) ? 3'd0 : index + 3'd1;
                end
            end
            STOP: begin
                if (count < LAST) begin
                    count_n = count + ONE;
                end else begin
                    count_n  = '0;
                    active_n = 1'b0;
                    if (r_sync) begin
                        rx_byte_n = r_byte;
                        dv_n      = 1'b1;
                    end else begin
                        ferr_n = 1'b1;
                    end
                end
            end
            default: begin
                // IDLE, WAIT_IDLE and illegal encodings
                count_n  = '0;
                index_n  = '0;
                active_n = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx at CLKS_PER_BIT=8 with a bit-accurate line driver.
module tb_uart_rx;

    localparam int CPB     = 8;
    localparam int LATENCY = 3 + 3 + 9 * CPB; // edge of DV/FE after start capture

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx = 1'b1;
    logic       dv, ferr, active;
    logic [7:0] rx_byte;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    logic [7:0] last_good = 8'h00;

    typedef struct {
        bit         ferr;
        logic [7:0] data;
        int         cyc;
    } exp_t;
    exp_t sb[$];

    uart_rx #(.CLKS_PER_BIT(CPB)) dut (
        .i_Clock     (clk),
        .i_Rst_L     (rst_n),
        .i_RX_Serial (rx),
        .o_RX_DV     (dv),
        .o_RX_Byte   (rx_byte),
        .o_RX_Active (active),
        .o_Frame_Err (ferr)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cyc %0d)", nm, act, exp, cyc);
        end
    endtask

    // Call at a negedge; returns at a negedge so frames chain with no gap.
    // limit >= 0 abandons the frame after that many clocks (no expectation pushed).
    task automatic send_frame(input logic [7:0] d, input bit stop_bit, input int limit);
        logic [9:0] bits;
        exp_t e;
        int n;
        bits = {stop_bit, d, 1'b0};
        if (limit < 0) begin
            e.ferr = !stop_bit;
            e.data = stop_bit ? d : last_good;
            e.cyc  = cyc + 1 + LATENCY;
            sb.push_back(e);
            if (stop_bit) last_good = d;
        end
        n = 0;
        for (int b = 0; b < 10; b++) begin
            for (int k = 0; k < CPB; k++) begin
                if (limit >= 0 && n >= limit) return;
                rx = bits[b];
                n++;
                @(negedge clk);
            end
        end
    endtask

    task automatic quiet(input int n, input string nm);
        bit seen;
        seen = 1'b0;
        repeat (n) begin
            @(negedge clk);
            if (active !== 1'b0) seen = 1'b1;
        end
        chk(nm, {31'd0, seen}, 32'd0);
    endtask

    // Monitor: every output pulse must match the head of the scoreboard.
    always @(negedge clk) begin
        if (rst_n) begin
            if (dv && ferr) chk("dv_and_ferr", 32'd1, 32'd0);
            if (dv || ferr) begin
                if (sb.size() == 0) begin
                    chk("unexpected_pulse", {30'd0, dv, ferr}, 32'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("pulse_kind", {31'd0, ferr}, {31'd0, e.ferr});
                    chk("rx_byte",    {24'd0, rx_byte}, {24'd0, e.data});
                    chk("pulse_cyc",  cyc, e.cyc);
                end
            end
        end
    end

    initial begin
        // Reset values, then release with line high.
        repeat (3) @(negedge clk);
        chk("rst_dv",     {31'd0, dv},      32'd0);
        chk("rst_byte",   {24'd0, rx_byte}, 32'd0);
        chk("rst_active", {31'd0, active},  32'd0);
        chk("rst_ferr",   {31'd0, ferr},    32'd0);
        rst_n = 1'b1;
        quiet(100, "idle_after_reset");

        send_frame(8'hA5, 1'b1, -1);
        quiet(10, "idle_after_a5");

        // Back-to-back, no idle gap.
        send_frame(8'h00, 1'b1, -1);
        send_frame(8'hFF, 1'b1, -1);
        send_frame(8'h55, 1'b1, -1);
        quiet(10, "idle_after_burst");

        // Start glitch: two clocks low.
        rx = 1'b0;
        repeat (2) @(negedge clk);
        rx = 1'b1;
        quiet(30, "glitch_no_active");

        // Bad stop bit, then break held low, then a good frame.
        send_frame(8'h3C, 1'b0, -1);
        quiet(40, "break_no_restart");
        rx = 1'b1;
        quiet(8, "break_released");
        send_frame(8'h81, 1'b1, -1);
        quiet(10, "idle_after_81");

        // Reset in the middle of data bit 4.
        send_frame(8'hC3, 1'b1, 5 * CPB + 4);
        rst_n = 1'b0;
        #1;
        chk("midrst_dv",     {31'd0, dv},      32'd0);
        chk("midrst_byte",   {24'd0, rx_byte}, 32'd0);
        chk("midrst_active", {31'd0, active},  32'd0);
        chk("midrst_ferr",   {31'd0, ferr},    32'd0);
        rx = 1'b1;
        last_good = 8'h00;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        quiet(20, "idle_after_midrst");
        send_frame(8'h7E, 1'b1, -1);

        repeat (20) @(negedge clk);
        chk("sb_empty", sb.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- UART receiver, 8N1: 8 data bits LSB first, one start bit, one stop bit, no parity.
- Pairs with the existing UART transmitter on the same link and uses the same CLKS_PER_BIT convention.
- Synchronises the asynchronous serial line, rejects start-bit glitches and samples each bit at its midpoint.
- Presents each received byte with a one-cycle valid pulse. Stop-bit violations are flagged as framing errors.

Parameters:
- CLKS_PER_BIT, 217, i_Clock cycles per UART bit (Fclk/baud). Legal range is 4 or more.

Ports:
- i_Clock  in  1  system clock
- i_Rst_L  in  1  asynchronous, active-low reset
- i_RX_Serial  in  1  asynchronous serial line; idles high
- o_RX_DV  out  1  one-cycle pulse; o_RX_Byte is valid on this cycle
- o_RX_Byte  out  8  last correctly framed byte
- o_RX_Active  out  1  high while a frame is being received
- o_Frame_Err  out  1  one-cycle pulse; stop bit was sampled as 0

Behaviour:
- Reset (asynchronous, active-low) values:
  - Both synchroniser flops = 1, so release from reset never triggers a false start.
  - FSM = IDLE; counters = 0.
  - o_RX_DV = 0, o_RX_Byte = 8'h00, o_RX_Active = 0, o_Frame_Err = 0.
- Synchroniser: 2-flop, i_RX_Serial -> r_Sync. The FSM reads only r_Sync.
- HALF = (CLKS_PER_BIT-1)/2, integer division. Clock counter width is $clog2(CLKS_PER_BIT)+1. Bit index is 3 bits.
- o_RX_DV and o_Frame_Err default to 0 every cycle. They are never high together.
- IDLE:
  - count = 0, index = 0, o_RX_Active = 0.
  - r_Sync == 0 -> START.
- START: each cycle, if count < HALF then count++. Otherwise:
  - r_Sync == 0 -> DATA, count = 0, o_RX_Active = 1.
  - r_Sync == 1 -> IDLE. Glitch: no output pulse.
- DATA: each cycle, if count < CLKS_PER_BIT-1 then count++. Otherwise:
  - r_Byte[index] <= r_Sync; count = 0.
  - index < 7 -> index++.
  - index == 7 -> index = 0, go to STOP.
- STOP: each cycle, if count < CLKS_PER_BIT-1 then count++. Otherwise sample r_Sync:
  - 1 -> o_RX_Byte <= r_Byte, o_RX_DV pulse, o_RX_Active = 0, go to IDLE.
  - 0 -> o_Frame_Err pulse, o_RX_Byte unchanged, o_RX_Active = 0, go to WAIT_IDLE.
- WAIT_IDLE: stay until r_Sync == 1, then go to IDLE. A held-low (break) line therefore cannot retrigger a start.
- Latency: let edge 0 be the first i_Clock edge that captures the low start bit.
  - The FSM enters START at edge 2.
  - The start bit is checked at edge 3+HALF.
  - o_RX_DV / o_Frame_Err is registered at edge 3+HALF+9*CLKS_PER_BIT.
- Back-to-back frames: because the stop bit is sampled mid-bit, IDLE is re-entered with about half a bit of margin. A start edge arriving immediately after the stop bit must be caught.
- o_RX_Byte holds its value between frames and after framing errors.
- Reset mid-frame aborts the frame: no pulse, partial byte discarded.
- Unused FSM encodings -> IDLE.

Decomposition:
- Package uart_pkg holds:
  - the rx state enum IDLE / START / DATA / STOP / WAIT_IDLE, 3 bits;
  - the function half_bit(clks) returning (clks-1)/2.
- One sub-module: uart_sync_2ff.
  - 2-flop synchroniser with reset value parameter RST_VAL (set to 1 here).
  - Reusable for other async inputs.

Test Plan (CLKS_PER_BIT=8, HALF=3; bench drives bits with the existing transmitter or a bit-accurate model):
- Frame 8'hA5 with good stop -> o_RX_DV high for exactly 1 cycle at edge 78 after start capture; o_RX_Byte = 8'hA5; o_Frame_Err stays 0.
- Back-to-back 8'h00, 8'hFF, 8'h55 with no idle gap -> three DV pulses; bytes received in order; no errors.
- Start glitch: line low for 2 clocks then high -> FSM returns to IDLE; o_RX_Active never asserts; no pulses.
- Stop bit forced 0 on 8'h3C, line held low 40 clocks, then a good 8'h81 -> one o_Frame_Err pulse, o_RX_Byte keeps its old value; no restart while low; then DV with 8'h81.
- i_Rst_L pulsed low mid-frame, during data bit 4 -> all outputs immediately at reset values; no DV for that frame; the next frame 8'h7E is received correctly.
- Release from reset with line high -> no activity; o_RX_Active = 0 for 100 cycles.
